// File: rtl/pps_pulse_analyzer_if.sv
// Purpose: measurement bus of the PPS pulse analyzer. Carries the enable, the two
// asynchronous timing inputs and the registered measurement results.
// Ports (signals):
//   i_enable      measurement enable
//   i_pps_raw     raw PPS reference (asynchronous)
//   i_pulse_in    divided pulse under test (asynchronous)
//   o_phase_us    PPS rise to pulse rise, us
//   o_width_us    pulse high time, us, saturating
//   o_period_pps  PPS edges between successive pulse rises
//   o_valid       one-cycle result strobe
//   o_width_ovf   width saturated in the reported measurement
//   o_timeout     period counter saturated with no new pulse
//   o_err         pulse rise with no preceding PPS edge
// Modports: master drives the inputs, slave is the analyzer.
interface pps_pulse_analyzer_if;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned CNT_W   = 8;

    logic               i_enable;
    logic               i_pps_raw;
    logic               i_pulse_in;
    logic [PHASE_W-1:0] o_phase_us;
    logic [CNT_W-1:0]   o_width_us;
    logic [CNT_W-1:0]   o_period_pps;
    logic               o_valid;
    logic               o_width_ovf;
    logic               o_timeout;
    logic               o_err;

    modport master (
        output i_enable, i_pps_raw, i_pulse_in,
        input  o_phase_us, o_width_us, o_period_pps,
        input  o_valid, o_width_ovf, o_timeout, o_err
    );

    modport slave (
        input  i_enable, i_pps_raw, i_pulse_in,
        output o_phase_us, o_width_us, o_period_pps,
        output o_valid, o_width_ovf, o_timeout, o_err
    );
endinterface

// File: rtl/pps_pulse_analyzer.sv
// Purpose: measures a divided PPS pulse train against the raw PPS reference and
// reports phase offset (us), pulse width (us) and period (PPS seconds).
// Ports:
//   i_clk_10  10 MHz system clock
//   i_rst     asynchronous active-high reset
//   bus       pps_pulse_analyzer_if.slave measurement bus
module pps_pulse_analyzer #(
    parameter int unsigned c_CLKS_PER_1_US = 10
) (
    input  logic                 i_clk_10,
    input  logic                 i_rst,
    pps_pulse_analyzer_if.slave  bus
);
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PRE_W   = (c_CLKS_PER_1_US > 1) ? $clog2(c_CLKS_PER_1_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(c_CLKS_PER_1_US - 1);
    // The anchor cycle itself counts as the first clock of the distance, so the
    // counters read floor(D / c_CLKS_PER_1_US) D cycles after the anchor.
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'((c_CLKS_PER_1_US > 1) ? 1 : 0);
    localparam logic             CNT_LOAD = (c_CLKS_PER_1_US > 1) ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PPS,
        MEAS_PHASE,
        MEAS_WIDTH,
        MEAS_PERIOD
    } state_t;

    state_t state_q, state_d;

    logic [2:0]         pps_sync, pul_sync;
    logic               pps_rise, pul_rise, pul_fall;

    logic [PRE_W-1:0]   phase_presc, width_presc;
    logic [PHASE_W-1:0] phase_cnt, phase_pend, phase_val;
    logic [CNT_W-1:0]   width_cnt, width_pend;
    logic [CNT_W-1:0]   period_cnt, period_inc, report_period;
    logic               ovf_pend;

    logic               anchor, start_width, inc_period, clr_period;
    logic               ld_phase, ld_width, report;
    logic               set_err, set_timeout, clr_flags;

    logic [PHASE_W-1:0] phase_q;
    logic [CNT_W-1:0]   width_q, period_q;
    logic               valid_q, ovf_q, timeout_q, err_q;

    // Two-flop synchronisers plus an edge-detect flop; both paths identical.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            pps_sync <= '0;
            pul_sync <= '0;
        end else begin
            pps_sync <= {pps_sync[1:0], bus.i_pps_raw};
            pul_sync <= {pul_sync[1:0], bus.i_pulse_in};
        end
    end

    assign pps_rise = pps_sync[1] & ~pps_sync[2];
    assign pul_rise = pul_sync[1] & ~pul_sync[2];
    assign pul_fall = ~pul_sync[1] & pul_sync[2];

    assign period_inc    = (period_cnt == '1) ? period_cnt : period_cnt + CNT_W'(1);
    assign report_period = pps_rise ? period_inc : period_cnt;

    // State register.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        anchor      = 1'b0;
        start_width = 1'b0;
        inc_period  = 1'b0;
        clr_period  = 1'b0;
        ld_phase    = 1'b0;
        phase_val   = phase_cnt;
        ld_width    = 1'b0;
        report      = 1'b0;
        set_err     = 1'b0;
        set_timeout = 1'b0;
        clr_flags   = 1'b0;

        if (!bus.i_enable) begin
            state_d   = IDLE;
            clr_flags = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_PPS;

                WAIT_PPS: begin
                    if (pps_rise) begin
                        anchor = 1'b1;
                        if (pul_rise) begin
                            ld_phase    = 1'b1;
                            phase_val   = '0;
                            start_width = 1'b1;
                            clr_period  = 1'b1;
                            state_d     = MEAS_WIDTH;
                        end else begin
                            state_d = MEAS_PHASE;
                        end
                    end
                end

                MEAS_PHASE: begin
                    if (pps_rise) anchor = 1'b1;
                    if (pul_rise) begin
                        ld_phase    = 1'b1;
                        phase_val   = pps_rise ? '0 : phase_cnt;
                        start_width = 1'b1;
                        clr_period  = 1'b1;
                        state_d     = MEAS_WIDTH;
                    end
                end

                MEAS_WIDTH: begin
                    if (pps_rise) begin
                        anchor     = 1'b1;
                        inc_period = 1'b1;
                    end
                    if (pul_fall) begin
                        ld_width = 1'b1;
                        state_d  = MEAS_PERIOD;
                    end
                end

                MEAS_PERIOD: begin
                    if (pps_rise) begin
                        anchor     = 1'b1;
                        inc_period = 1'b1;
                    end
                    if (pul_rise) begin
                        // A coincident PPS edge counts before the pulse is judged.
                        if (pps_rise || period_cnt != '0) begin
                            report      = 1'b1;
                            ld_phase    = 1'b1;
                            phase_val   = pps_rise ? '0 : phase_cnt;
                            start_width = 1'b1;
                            clr_period  = 1'b1;
                            state_d     = MEAS_WIDTH;
                        end else begin
                            set_err = 1'b1;
                            state_d = WAIT_PPS;
                        end
                    end else if (period_cnt == '1) begin
                        set_timeout = 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Phase timebase: free-running from the latest PPS anchor, saturating.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            phase_presc <= '0;
            phase_cnt   <= '0;
        end else if (anchor) begin
            phase_presc <= PRE_LOAD;
            phase_cnt   <= PHASE_W'(CNT_LOAD);
        end else if (phase_presc == PRE_MAX) begin
            phase_presc <= '0;
            if (phase_cnt != '1) phase_cnt <= phase_cnt + PHASE_W'(1);
        end else begin
            phase_presc <= phase_presc + PRE_W'(1);
        end
    end

    // Width timebase: runs only while the pulse is high, anchored on its rise.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            width_presc <= '0;
            width_cnt   <= '0;
            ovf_pend    <= 1'b0;
        end else if (start_width) begin
            width_presc <= PRE_LOAD;
            width_cnt   <= CNT_W'(CNT_LOAD);
            ovf_pend    <= 1'b0;
        end else if (state_q == MEAS_WIDTH) begin
            if (width_presc == PRE_MAX) begin
                width_presc <= '0;
                if (width_cnt != '1) begin
                    width_cnt <= width_cnt + CNT_W'(1);
                    if (width_cnt == CNT_W'(254)) ovf_pend <= 1'b1;
                end
            end else begin
                width_presc <= width_presc + PRE_W'(1);
            end
        end
    end

    // Period counter and pending results.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            period_cnt <= '0;
            phase_pend <= '0;
            width_pend <= '0;
        end else begin
            if (clr_period)      period_cnt <= '0;
            else if (inc_period) period_cnt <= period_inc;
            if (ld_phase) phase_pend <= phase_val;
            if (ld_width) width_pend <= width_cnt;
        end
    end

    // Registered outputs; disable clears the flags but holds the last results.
    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            phase_q   <= '0;
            width_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= report;
            if (report) begin
                phase_q   <= phase_pend;
                width_q   <= width_pend;
                period_q  <= report_period;
                ovf_q     <= ovf_pend;
                timeout_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (set_err) err_q <= 1'b1;
            if (clr_flags) begin
                ovf_q     <= 1'b0;
                timeout_q <= 1'b0;
                err_q     <= 1'b0;
            end
        end
    end

    assign bus.o_phase_us   = phase_q;
    assign bus.o_width_us   = width_q;
    assign bus.o_period_pps = period_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_width_ovf  = ovf_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_err        = err_q;
endmodule

// File: tb/tb_pps_pulse_analyzer.sv
// Purpose: directed self-checking bench for pps_pulse_analyzer.
// Drives PPS and pulse patterns cycle by cycle and checks each o_valid report
// and the status flags against hand-computed values (10 clocks per us).
`timescale 1ns/1ps
module tb_pps_pulse_analyzer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_bad = 0;

    int unsigned q_phase[$];
    int unsigned q_width[$];
    int unsigned q_period[$];
    int unsigned q_ovf[$];

    pps_pulse_analyzer_if bus();

    pps_pulse_analyzer #(.c_CLKS_PER_1_US(10)) dut (
        .i_clk_10 (clk),
        .i_rst    (rst),
        .bus      (bus)
    );

    always #50 clk = ~clk;

    // Record every result strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            q_phase.push_back(int'(bus.o_phase_us));
            q_width.push_back(int'(bus.o_width_us));
            q_period.push_back(int'(bus.o_period_pps));
            q_ovf.push_back(int'(bus.o_width_ovf));
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        q_phase.delete();
        q_width.delete();
        q_period.delete();
        q_ovf.delete();
    endtask

    // Hold both inputs at fixed levels for n cycles.
    task automatic drive(input logic pps, input logic pul, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_pps_raw  = pps;
            bus.i_pulse_in = pul;
            @(posedge clk);
            #1;
        end
    endtask

    // PPS every p cycles (5 cycles high); pulse every 'every' PPS seconds,
    // rising 'off' cycles after the PPS rise and high for 'high' cycles.
    task automatic run(input int p, input int every, input int off, input int high, input int n);
        for (int t = 0; t < n; t++) begin
            int tt;
            tt = t % (p * every);
            bus.i_pps_raw  = ((t % p) < 5);
            bus.i_pulse_in = (tt >= off) && (tt < off + high);
            @(posedge clk);
            #1;
        end
        bus.i_pps_raw  = 1'b0;
        bus.i_pulse_in = 1'b0;
    endtask

    task automatic restart();
        bus.i_enable = 1'b0;
        drive(1'b0, 1'b0, 3);
        bus.i_enable = 1'b1;
        drive(1'b0, 1'b0, 4);
        clear_q();
    endtask

    task automatic chk_reports(input string tag, input int n, input int ph,
                               input int wd, input int pr, input int ov);
        chk({tag, "_count"}, 32'(q_phase.size()), 32'(n));
        for (int i = 0; i < q_phase.size(); i++) begin
            chk({tag, "_phase"},  32'(q_phase[i]),  32'(ph));
            chk({tag, "_width"},  32'(q_width[i]),  32'(wd));
            chk({tag, "_period"}, 32'(q_period[i]), 32'(pr));
            chk({tag, "_ovf"},    32'(q_ovf[i]),    32'(ov));
        end
    endtask

    initial begin
        bus.i_enable   = 1'b0;
        bus.i_pps_raw  = 1'b0;
        bus.i_pulse_in = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase",   32'(bus.o_phase_us),   32'd0);
        chk("rst_width",   32'(bus.o_width_us),   32'd0);
        chk("rst_period",  32'(bus.o_period_pps), 32'd0);
        chk("rst_valid",   32'(bus.o_valid),      32'd0);
        chk("rst_ovf",     32'(bus.o_width_ovf),  32'd0);
        chk("rst_timeout", 32'(bus.o_timeout),    32'd0);
        chk("rst_err",     32'(bus.o_err),        32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2);

        // Periodic lock: rise 1001 cycles after PPS, 500 high, every 3rd PPS.
        restart();
        run(2000, 3, 1001, 500, 24000);
        drive(1'b0, 1'b0, 8);
        chk_reports("lock", 3, 100, 50, 3, 0);

        // Zero phase: pulse coincident with PPS, 20 cycles high, every PPS.
        restart();
        run(200, 1, 0, 20, 800);
        drive(1'b0, 1'b0, 8);
        chk_reports("zero", 3, 0, 2, 1, 0);

        // Width saturation: two 3000-cycle pulses, then two 500-cycle pulses.
        restart();
        run(5000, 1, 1001, 3000, 10000);
        run(5000, 1, 1001, 500, 10000);
        drive(1'b0, 1'b0, 8);
        chk("sat_count", 32'(q_phase.size()), 32'd3);
        if (q_phase.size() == 3) begin
            chk("sat_w0",   32'(q_width[0]),  32'd255);
            chk("sat_ovf0", 32'(q_ovf[0]),    32'd1);
            chk("sat_w1",   32'(q_width[1]),  32'd255);
            chk("sat_ovf1", 32'(q_ovf[1]),    32'd1);
            chk("sat_w2",   32'(q_width[2]),  32'd50);
            chk("sat_ovf2", 32'(q_ovf[2]),    32'd0);
            chk("sat_ph2",  32'(q_phase[2]),  32'd100);
            chk("sat_pr2",  32'(q_period[2]), 32'd1);
        end
        chk("sat_ovf_level", 32'(bus.o_width_ovf), 32'd0);

        // Non-periodic: one pulse, then PPS only; 254 edges, then the 255th.
        restart();
        run(100, 300, 11, 20, 25500);
        chk("np_timeout_254", 32'(bus.o_timeout), 32'd0);
        run(100, 1, 0, 0, 300);
        drive(1'b0, 1'b0, 8);
        chk("np_timeout_255", 32'(bus.o_timeout), 32'd1);
        chk("np_count",       32'(q_phase.size()), 32'd0);

        // Error: second pulse rise before any PPS in MEAS_PERIOD.
        restart();
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 45);
        drive(1'b0, 1'b1, 30);
        drive(1'b0, 1'b0, 70);
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 10);
        chk("err_set",   32'(bus.o_err),       32'd1);
        chk("err_count", 32'(q_phase.size()), 32'd0);
        // Recovery from WAIT_PPS; error stays sticky.
        run(500, 1, 101, 50, 1500);
        drive(1'b0, 1'b0, 8);
        chk_reports("recov", 2, 10, 5, 1, 0);
        chk("err_sticky", 32'(bus.o_err), 32'd1);
        bus.i_enable = 1'b0;
        drive(1'b0, 1'b0, 3);
        chk("err_cleared", 32'(bus.o_err), 32'd0);
        chk("dis_hold_ph", 32'(bus.o_phase_us), 32'd10);

        // Disable in MEAS_PHASE: no report, results held.
        clear_q();
        bus.i_enable = 1'b1;
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 20);
        bus.i_enable = 1'b0;
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 10);
        chk("dis_count",  32'(q_phase.size()),   32'd0);
        chk("dis_phase",  32'(bus.o_phase_us),   32'd10);
        chk("dis_width",  32'(bus.o_width_us),   32'd5);
        chk("dis_period", 32'(bus.o_period_pps), 32'd1);

        // Async reset during MEAS_WIDTH.
        bus.i_enable = 1'b1;
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 30);
        chk("pre_rst_phase", 32'(bus.o_phase_us), 32'd10);
        #20;
        rst = 1'b1;
        #1;
        chk("arst_phase",   32'(bus.o_phase_us),   32'd0);
        chk("arst_width",   32'(bus.o_width_us),   32'd0);
        chk("arst_period",  32'(bus.o_period_pps), 32'd0);
        chk("arst_valid",   32'(bus.o_valid),      32'd0);
        chk("arst_ovf",     32'(bus.o_width_ovf),  32'd0);
        chk("arst_timeout", 32'(bus.o_timeout),    32'd0);
        chk("arst_err",     32'(bus.o_err),        32'd0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // The discarded measurement must not produce a report afterwards.
        clear_q();
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        chk("post_rst_count", 32'(q_phase.size()), 32'd0);
        chk("post_rst_err",   32'(bus.o_err),      32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
